// File: rtl/huffman_enc_arb.sv
`default_nettype none
// ============================================================================
//  Module   : huffman_enc_arb
//  Purpose  : Round-robin packet arbiter feeding one Huffman encoder; tracks
//             the partial-byte fill and optionally pads it at packet end.
//  Option   : define HUFF_ARB_PAD_EN to enable the one-cycle pad symbol.
//  Revision : 1.0 - initial release
// ============================================================================
module huffman_enc_arb #(
    parameter int W = 8,
    parameter int C = 4,
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_valid,
    input  logic [N*W-1:0]   req_d,
    input  logic [N*C-1:0]   req_w,
    input  logic [N-1:0]     req_last,
    output logic [N-1:0]     req_ready,
    output logic [W-1:0]     enc_d,
    output logic [C-1:0]     enc_w,
    output logic             enc_en,
    output logic [N-1:0]     grant,
    output logic             busy,
    output logic             err
);

    localparam int           c_IW    = (N > 1) ? $clog2(N) : 1;
    localparam logic [C-1:0] c_WLEN  = C'(W);
    localparam logic [C-1:0] c_FMASK = C'(W - 1);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_GRANT = 2'd1;
`ifdef HUFF_ARB_PAD_EN
    localparam logic [1:0] c_S_PAD   = 2'd2;
`endif

    logic [1:0]      r_state;
    logic [N-1:0]    r_grant;
    logic [c_IW-1:0] r_gidx;
    logic [c_IW-1:0] r_rr_ptr;
    logic [C-1:0]    r_fill;
    logic            r_enc_en;
    logic [W-1:0]    r_enc_d;
    logic [C-1:0]    r_enc_w;
    logic            r_err;

    logic            w_pick_ok;
    logic [c_IW-1:0] w_pick_idx;
    int              w_scan;
    logic [W-1:0]    w_sel_d;
    logic [C-1:0]    w_sel_w;
    logic            w_sel_last;
    logic            w_xfer;
    logic            w_legal;
    logic [C-1:0]    w_fill_next;
    logic [c_IW-1:0] w_ptr_next;

    // Scan from the highest offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        w_pick_ok  = 1'b0;
        w_pick_idx = '0;
        w_scan     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            w_scan = int'(r_rr_ptr) + k;
            if (w_scan >= N) begin
                w_scan = w_scan - N;
            end
            if (req_valid[c_IW'(w_scan)]) begin
                w_pick_ok  = 1'b1;
                w_pick_idx = c_IW'(w_scan);
            end
        end
    end

    assign w_sel_d     = req_d[r_gidx * W +: W];
    assign w_sel_w     = req_w[r_gidx * C +: C];
    assign w_sel_last  = req_last[r_gidx];
    assign w_xfer      = (r_state == c_S_GRANT) && req_valid[r_gidx] && !rst;
    assign w_legal     = (w_sel_w != '0) && (w_sel_w <= c_WLEN);
    // W is a power of two, so masking gives the modulo; illegal lengths leave fill alone.
    assign w_fill_next = w_legal ? ((r_fill + w_sel_w) & c_FMASK) : r_fill;
    assign w_ptr_next  = (r_gidx == c_IW'(N - 1)) ? '0 : r_gidx + 1'b1;

    assign req_ready = ((r_state == c_S_GRANT) && !rst) ? r_grant : '0;
    assign busy      = (r_state != c_S_IDLE);
    assign grant     = r_grant;
    assign enc_en    = r_enc_en;
    assign enc_d     = r_enc_d;
    assign enc_w     = r_enc_w;
    assign err       = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_S_IDLE;
            r_grant  <= '0;
            r_gidx   <= '0;
            r_rr_ptr <= '0;
            r_fill   <= '0;
            r_enc_en <= 1'b0;
            r_enc_d  <= '0;
            r_enc_w  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_enc_en <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (w_pick_ok) begin
                        r_grant <= N'(1) << w_pick_idx;
                        r_gidx  <= w_pick_idx;
                        r_state <= c_S_GRANT;
                    end
                end
                c_S_GRANT: begin
                    if (w_xfer) begin
                        if (w_legal) begin
                            r_enc_en <= 1'b1;
                            r_enc_d  <= w_sel_d;
                            r_enc_w  <= w_sel_w;
                        end else begin
                            r_err <= 1'b1;
                        end
                        r_fill <= w_fill_next;
                        if (w_sel_last) begin
                            r_rr_ptr <= w_ptr_next;
`ifdef HUFF_ARB_PAD_EN
                            if (w_fill_next != '0) begin
                                r_state <= c_S_PAD;
                            end else begin
                                r_state <= c_S_IDLE;
                                r_grant <= '0;
                                r_fill  <= '0;
                            end
`else
                            r_state <= c_S_IDLE;
                            r_grant <= '0;
                            r_fill  <= '0;
`endif
                        end
                    end
                end
`ifdef HUFF_ARB_PAD_EN
                c_S_PAD: begin
                    r_enc_en <= 1'b1;
                    r_enc_d  <= '0;
                    r_enc_w  <= c_WLEN - r_fill;
                    r_fill   <= '0;
                    r_grant  <= '0;
                    r_state  <= c_S_IDLE;
                end
`endif
                default: begin
                    r_state <= c_S_IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/huffman_enc_arb.md
HUFFMAN_ENC_ARB -- requirements
Module: huffman_enc_arb

Interface
REQ-001 The block SHALL have parameter W, default 8, meaning code word / output byte width in bits (power of 2).
REQ-002 The block SHALL have parameter C, default 4, meaning width of the code-length field (W must fit in C bits).
REQ-003 The block SHALL have parameter N, default 4, meaning number of requester lanes (2..8).
REQ-004 The block SHALL have these ports, one per line as name, direction, width, meaning:
  clk  in  1  single clock, all logic on rising edge
  rst  in  1  synchronous active-high reset
  req_valid  in  N  per-lane symbol valid
  req_d  in  N*W  per-lane code, MSB-aligned, lane i at [i*W +: W]
  req_w  in  N*C  per-lane code length in bits, lane i at [i*C +: C]
  req_last  in  N  per-lane last symbol of packet
  req_ready  out  N  per-lane accept; transfer = valid & ready
  enc_d  out  W  code to encoder d_in
  enc_w  out  C  length to encoder w_in
  enc_en  out  1  encoder enable, one symbol per high cycle
  grant  out  N  one-hot owning lane, 0 when idle
  busy  out  1  high in GRANT or PAD
  err  out  1  sticky illegal-length flag

Function
REQ-005 The FSM SHALL have states IDLE, GRANT, PAD.
REQ-006 In IDLE, the block SHALL pick the first lane with req_valid high, searching from rr_ptr upward with wrap mod N, register it in grant, and enter GRANT next cycle; no valid lane means stay in IDLE.
REQ-007 req_ready SHALL equal grant[i] while in GRANT and SHALL be 0 in IDLE and PAD (combinational from state).
REQ-008 Each transfer SHALL drive enc_d=req_d, enc_w=req_w, enc_en=1 on the following cycle (registered, latency 1); enc_en SHALL be 0 in every cycle without a transfer or pad.
REQ-009 The grant SHALL be held for the whole packet until a transfer with req_last=1; non-granted lanes' valid SHALL be ignored.
REQ-010 fill (C bits) SHALL update to (fill + req_w) mod W on every legal transfer and SHALL be cleared to 0 at each packet end.
REQ-011 A transfer with req_w=0 or req_w>W SHALL be accepted (ready honoured) with enc_en suppressed, fill unchanged, and err set until reset.
REQ-012 On the last transfer: if the pad feature is active and the updated fill is nonzero, go to PAD; otherwise go to IDLE.
REQ-013 PAD SHALL last exactly one cycle, emitting enc_en=1, enc_d=0, enc_w=W-fill, then enter IDLE.
REQ-014 At packet end, rr_ptr SHALL become (granted index + 1) mod N.
REQ-015 Minimum gap between packets SHALL be one IDLE cycle (arbitration bubble); back-to-back symbols within a packet SHALL run at one per cycle.
REQ-016 A lane dropping req_valid mid-packet SHALL stall: grant and fill are held and enc_en stays 0.
REQ-017 busy SHALL be 1 exactly in GRANT and PAD.

Reset
REQ-018 When rst=1 at a clock edge, the block SHALL set state=IDLE, grant=0, rr_ptr=0, fill=0, enc_en=0, enc_d=0, enc_w=0, err=0.
REQ-019 req_ready SHALL be 0 during reset.
REQ-020 Reset mid-packet or mid-PAD SHALL abandon the packet with no pad emitted.

Configuration
REQ-021 With macro HUFF_ARB_PAD_EN defined, REQ-013 padding SHALL be active.
REQ-022 Without HUFF_ARB_PAD_EN, the PAD state SHALL be absent, the last transfer SHALL go directly to IDLE, and the partial byte SHALL be left to the encoder.

Verification
REQ-023 Single lane packet: lane0 sends 4x {w=2} with last on the 4th -> 4 enc_en pulses at latency 1; fill returns to 0; no pad; IDLE next cycle.
REQ-024 Pad (macro on): lane1 sends w=3, w=2 (last) -> fill=5, PAD emits enc_w=3, enc_d=0; without macro, no PAD cycle.
REQ-025 Round robin: lanes 0 and 2 valid continuously, 1-symbol packets -> grant order 0,2,0,2 with one IDLE cycle between packets.
REQ-026 Illegal length: lane3 sends w=0 then w=9 (C=4) -> both accepted, enc_en stays 0, err=1 and remains 1 until rst.
REQ-027 Stall and reset: lane0 drops valid for 3 cycles mid-packet -> grant held, enc_en=0; rst asserted in GRANT -> next cycle grant=0, state IDLE, no pad.
REQ-028 Mixed widths w=2,4,2,8,6,2 on one lane -> enc_w sequence matches the input sequence, and fill is 0 after the 8-bit and final symbols.
